// File: rtl/pingpong_rd_pkg.sv
// Shared types and constants for the ping-pong read-side arbiter.
// Optional dout_last support is enabled with PINGPONG_RD_LAST_EN.
package pingpong_rd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BURST_A = 2'd1,
        BURST_B = 2'd2
    } rd_state_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    localparam int unsigned OBUF_DEPTH = 2;
    localparam int unsigned OCC_W      = $clog2(OBUF_DEPTH + 1);

    // True when a strobe issued now can still land in the output buffer
    function automatic logic credit_avail(
        input logic [OCC_W-1:0] occ,
        input logic             inflight,
        input logic             pop
    );
        logic [OCC_W:0] sum;
        sum = {1'b0, occ} + (OCC_W+1)'(inflight) - (OCC_W+1)'(pop);
        return sum < (OCC_W+1)'(OBUF_DEPTH);
    endfunction

endpackage

// File: rtl/rd_out_skid.sv
// Two-entry in-order output buffer; head entry drives the registered output stream.
// Carries a per-word last flag when PINGPONG_RD_LAST_EN is defined.
module rd_out_skid
    import pingpong_rd_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 16
) (
    input  logic                 rd_clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [DATA_SIZE-1:0] push_data,
    input  logic                 push_src,
`ifdef PINGPONG_RD_LAST_EN
    input  logic                 push_last,
    output logic                 dout_last,
`endif
    input  logic                 pop,
    output logic [OCC_W-1:0]     occ,
    output logic [DATA_SIZE-1:0] dout,
    output logic                 dout_valid,
    output logic                 dout_src
);

    logic [DATA_SIZE-1:0] tail_data, tail_data_nxt, head_data_nxt;
    logic                 tail_src, tail_src_nxt, head_src_nxt;
    logic                 tail_valid, tail_valid_nxt, head_valid_nxt;
    logic                 pop_eff;
`ifdef PINGPONG_RD_LAST_EN
    logic                 tail_last, tail_last_nxt, head_last_nxt;
`endif

    assign pop_eff = pop && dout_valid;
    assign occ     = OCC_W'(dout_valid) + OCC_W'(tail_valid);

    // Pop shifts tail into head first, then a push fills the first free slot
    always_comb begin
        head_data_nxt  = dout;
        head_src_nxt   = dout_src;
        head_valid_nxt = dout_valid;
        tail_data_nxt  = tail_data;
        tail_src_nxt   = tail_src;
        tail_valid_nxt = tail_valid;
`ifdef PINGPONG_RD_LAST_EN
        head_last_nxt  = dout_last;
        tail_last_nxt  = tail_last;
`endif
        if (pop_eff) begin
            head_data_nxt  = tail_data;
            head_src_nxt   = tail_src;
            head_valid_nxt = tail_valid;
            tail_valid_nxt = 1'b0;
`ifdef PINGPONG_RD_LAST_EN
            head_last_nxt  = tail_last;
`endif
        end
        if (push) begin
            if (!head_valid_nxt) begin
                head_data_nxt  = push_data;
                head_src_nxt   = push_src;
                head_valid_nxt = 1'b1;
`ifdef PINGPONG_RD_LAST_EN
                head_last_nxt  = push_last;
`endif
            end else if (!tail_valid_nxt) begin
                tail_data_nxt  = push_data;
                tail_src_nxt   = push_src;
                tail_valid_nxt = 1'b1;
`ifdef PINGPONG_RD_LAST_EN
                tail_last_nxt  = push_last;
`endif
            end
        end
    end

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_src   <= 1'b0;
            dout_valid <= 1'b0;
            tail_data  <= '0;
            tail_src   <= 1'b0;
            tail_valid <= 1'b0;
`ifdef PINGPONG_RD_LAST_EN
            dout_last  <= 1'b0;
            tail_last  <= 1'b0;
`endif
        end else begin
            dout       <= head_data_nxt;
            dout_src   <= head_src_nxt;
            dout_valid <= head_valid_nxt;
            tail_data  <= tail_data_nxt;
            tail_src   <= tail_src_nxt;
            tail_valid <= tail_valid_nxt;
`ifdef PINGPONG_RD_LAST_EN
            dout_last  <= head_last_nxt;
            tail_last  <= tail_last_nxt;
`endif
        end
    end

endmodule

// File: rtl/pingpong_rd_arb.sv
// Read-domain burst arbiter draining two async FIFOs into one valid/ready stream.
// Define PINGPONG_RD_LAST_EN to add the dout_last end-of-burst marker.
module pingpong_rd_arb
    import pingpong_rd_pkg::*;
#(
    parameter int unsigned DATA_SIZE  = 16,
    parameter int unsigned DEPTH_SIZE = 10,
    parameter int unsigned BURST_LEN  = 256
) (
    input  logic                  rd_clk,
    input  logic                  rst_n,
    input  logic                  a_empty,
    input  logic [DEPTH_SIZE:0]   a_rd_data_count,
    input  logic [DATA_SIZE-1:0]  a_rd_data,
    output logic                  a_rd_en,
    input  logic                  b_empty,
    input  logic [DEPTH_SIZE:0]   b_rd_data_count,
    input  logic [DATA_SIZE-1:0]  b_rd_data,
    output logic                  b_rd_en,
    output logic [DATA_SIZE-1:0]  dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_src,
`ifdef PINGPONG_RD_LAST_EN
    output logic                  dout_last,
`endif
    output logic                  busy
);

    localparam int unsigned CNT_W   = DEPTH_SIZE + 1;
    localparam int unsigned ISSUE_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0]   BURST_THR = CNT_W'(BURST_LEN);
    localparam logic [ISSUE_W-1:0] LAST_IDX  = ISSUE_W'(BURST_LEN - 1);

    rd_state_t            state, state_nxt;
    logic                 prio, prio_nxt;
    logic [ISSUE_W-1:0]   issue_cnt, issue_nxt;
    logic                 inflight, inflight_src;
    logic [OCC_W-1:0]     occ, occ_nxt;
    logic [DATA_SIZE-1:0] push_data;
    logic                 pop, credit_ok_c, a_elig_c, b_elig_c, busy_nxt;
`ifdef PINGPONG_RD_LAST_EN
    logic                 inflight_last, strobe_last_c;
`endif

    assign pop         = dout_valid && dout_ready;
    assign credit_ok_c = credit_avail(occ, inflight, pop);
    assign a_elig_c    = a_rd_data_count >= BURST_THR;
    assign b_elig_c    = b_rd_data_count >= BURST_THR;

    // Burst sequencing; strobes are gated by empty and output-buffer credit
    always_comb begin
        state_nxt = state;
        prio_nxt  = prio;
        issue_nxt = issue_cnt;
        a_rd_en   = 1'b0;
        b_rd_en   = 1'b0;
        case (state)
            IDLE: begin
                issue_nxt = '0;
                if (prio == SRC_A) begin
                    if (a_elig_c)      state_nxt = BURST_A;
                    else if (b_elig_c) state_nxt = BURST_B;
                end else begin
                    if (b_elig_c)      state_nxt = BURST_B;
                    else if (a_elig_c) state_nxt = BURST_A;
                end
            end
            BURST_A: begin
                if (!a_empty && credit_ok_c) begin
                    a_rd_en   = 1'b1;
                    issue_nxt = issue_cnt + ISSUE_W'(1);
                    if (issue_cnt == LAST_IDX) begin
                        state_nxt = IDLE;
                        prio_nxt  = ~prio;
                    end
                end
            end
            BURST_B: begin
                if (!b_empty && credit_ok_c) begin
                    b_rd_en   = 1'b1;
                    issue_nxt = issue_cnt + ISSUE_W'(1);
                    if (issue_cnt == LAST_IDX) begin
                        state_nxt = IDLE;
                        prio_nxt  = ~prio;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign occ_nxt  = occ + OCC_W'(inflight) - OCC_W'(pop);
    assign busy_nxt = (state_nxt != IDLE) || a_rd_en || b_rd_en || (occ_nxt != '0);

`ifdef PINGPONG_RD_LAST_EN
    assign strobe_last_c = (a_rd_en || b_rd_en) && (issue_cnt == LAST_IDX);
`endif

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            prio         <= SRC_A;
            issue_cnt    <= '0;
            inflight     <= 1'b0;
            inflight_src <= SRC_A;
            busy         <= 1'b0;
`ifdef PINGPONG_RD_LAST_EN
            inflight_last <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            prio         <= prio_nxt;
            issue_cnt    <= issue_nxt;
            inflight     <= a_rd_en || b_rd_en;
            inflight_src <= b_rd_en ? SRC_B : SRC_A;
            busy         <= busy_nxt;
`ifdef PINGPONG_RD_LAST_EN
            inflight_last <= strobe_last_c;
`endif
        end
    end

    // RAM output is valid the cycle after the strobe
    assign push_data = (inflight_src == SRC_B) ? b_rd_data : a_rd_data;

    rd_out_skid #(
        .DATA_SIZE(DATA_SIZE)
    ) u_skid (
        .rd_clk    (rd_clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (push_data),
        .push_src  (inflight_src),
`ifdef PINGPONG_RD_LAST_EN
        .push_last (inflight_last),
        .dout_last (dout_last),
`endif
        .pop       (pop),
        .occ       (occ),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_src  (dout_src)
    );

endmodule

// File: tb/tb_pingpong_rd_arb.sv
// Directed bench for pingpong_rd_arb with a small read-RAM model per buffer.
// Honours PINGPONG_RD_LAST_EN when defined.
module tb_pingpong_rd_arb;

    localparam int unsigned DW = 16;
    localparam int unsigned DS = 4;
    localparam int unsigned BL = 4;

    logic          rd_clk = 1'b0;
    logic          rst_n  = 1'b0;
    logic          a_empty = 1'b0, b_empty = 1'b0;
    logic [DS:0]   a_cnt = '0, b_cnt = '0;
    logic [DW-1:0] a_rd_data = '0, b_rd_data = '0;
    logic          a_rd_en, b_rd_en;
    logic [DW-1:0] dout;
    logic          dout_valid, dout_src, busy;
    logic          dout_ready = 1'b1;
`ifdef PINGPONG_RD_LAST_EN
    logic          dout_last;
    logic          acc_last[$];
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int a_ptr = 0, b_ptr = 0;
    int viol = 0, stab_err = 0;
    logic          hold_q = 1'b0;
    logic [DW-1:0] hold_data = '0;

    logic [DW-1:0] acc_data[$];
    logic          acc_src[$];
    int            acc_cyc[$];
    logic          strb_src[$];
    int            strb_cyc[$];

    pingpong_rd_arb #(
        .DATA_SIZE (DW),
        .DEPTH_SIZE(DS),
        .BURST_LEN (BL)
    ) dut (
        .rd_clk         (rd_clk),
        .rst_n          (rst_n),
        .a_empty        (a_empty),
        .a_rd_data_count(a_cnt),
        .a_rd_data      (a_rd_data),
        .a_rd_en        (a_rd_en),
        .b_empty        (b_empty),
        .b_rd_data_count(b_cnt),
        .b_rd_data      (b_rd_data),
        .b_rd_en        (b_rd_en),
        .dout           (dout),
        .dout_valid     (dout_valid),
        .dout_ready     (dout_ready),
        .dout_src       (dout_src),
`ifdef PINGPONG_RD_LAST_EN
        .dout_last      (dout_last),
`endif
        .busy           (busy)
    );

    always #5 rd_clk = ~rd_clk;

    always @(posedge rd_clk) cyc <= cyc + 1;

    // FIFO RAM models: word k of A reads as A000+k, of B as B000+k
    always @(posedge rd_clk) begin
        if (a_rd_en) begin
            a_rd_data <= 16'hA000 + 16'(a_ptr);
            a_ptr     <= a_ptr + 1;
        end
        if (b_rd_en) begin
            b_rd_data <= 16'hB000 + 16'(b_ptr);
            b_ptr     <= b_ptr + 1;
        end
    end

    // Observe strobes, accepted words and stability on the falling edge
    always @(negedge rd_clk) begin
        if (rst_n) begin
            if (a_rd_en) begin strb_src.push_back(1'b0); strb_cyc.push_back(cyc); end
            if (b_rd_en) begin strb_src.push_back(1'b1); strb_cyc.push_back(cyc); end
            if ((a_rd_en && a_empty) || (b_rd_en && b_empty) || (a_rd_en && b_rd_en))
                viol++;
            if (hold_q && !(dout_valid && dout == hold_data))
                stab_err++;
            if (dout_valid && dout_ready) begin
                acc_data.push_back(dout);
                acc_src.push_back(dout_src);
                acc_cyc.push_back(cyc);
`ifdef PINGPONG_RD_LAST_EN
                acc_last.push_back(dout_last);
`endif
            end
            hold_q    = dout_valid && !dout_ready;
            hold_data = dout;
        end else begin
            hold_q = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge rd_clk);
            #1;
        end
    endtask

    task automatic wait_strobes(input int n, input string tag);
        int budget;
        budget = 100;
        while (strb_src.size() < n && budget > 0) begin
            step(1);
            budget--;
        end
        if (budget == 0) check({"timeout_", tag}, 32'(strb_src.size()), 32'(n));
    endtask

    task automatic check_words(input string tag, input int first, input logic src,
                               input int ptr0, input int n);
        logic [15:0] base;
        logic [31:0] got;
        base = src ? 16'hB000 : 16'hA000;
        for (int k = 0; k < n; k++) begin
            if (first + k < acc_data.size())
                got = {15'd0, acc_src[first+k], acc_data[first+k]};
            else
                got = 32'hFFFF_FFFF;
            check($sformatf("%s_w%0d", tag, k), got, {15'd0, src, base + 16'(ptr0 + k)});
        end
    endtask

    initial begin
        int sb, ab;

        // Reset with both buffers holding enough data
        rst_n = 1'b0; a_cnt = 5'd8; b_cnt = 5'd8; dout_ready = 1'b1;
        step(3);
        check("rst_a_rd_en",    32'(a_rd_en),    32'd0);
        check("rst_b_rd_en",    32'(b_rd_en),    32'd0);
        check("rst_dout_valid", 32'(dout_valid), 32'd0);
        check("rst_dout",       32'(dout),       32'd0);
        check("rst_dout_src",   32'(dout_src),   32'd0);
        check("rst_busy",       32'(busy),       32'd0);
`ifdef PINGPONG_RD_LAST_EN
        check("rst_dout_last",  32'(dout_last),  32'd0);
`endif

        // First burst after release comes from A
        sb = strb_src.size(); ab = acc_data.size();
        rst_n = 1'b1;
        wait_strobes(sb + 1, "first");
        a_cnt = '0; b_cnt = '0;
        step(10);
        check("first_strobes", 32'(strb_src.size() - sb), 32'd4);
        check("first_src0",    32'(strb_src[sb]), 32'd0);
        check("first_consec",  32'(strb_cyc[sb+3] - strb_cyc[sb]), 32'd3);
        check("first_latency", 32'(acc_cyc[ab] - strb_cyc[sb]), 32'd2);
        check_words("first", ab, 1'b0, 0, 4);

        // Strict alternation with both buffers full
        rst_n = 1'b0; step(1); rst_n = 1'b1;
        sb = strb_src.size(); ab = acc_data.size();
        a_cnt = 5'd16; b_cnt = 5'd16;
        wait_strobes(sb + 13, "alt");
        a_cnt = '0; b_cnt = '0;
        step(12);
        check("alt_strobes", 32'(strb_src.size() - sb), 32'd16);
        check("alt_gap",     32'(strb_cyc[sb+4] - strb_cyc[sb+3]), 32'd2);
        check_words("alt_b1", ab,      1'b0, 4, 4);
        check_words("alt_b2", ab + 4,  1'b1, 0, 4);
        check_words("alt_b3", ab + 8,  1'b0, 8, 4);
        check_words("alt_b4", ab + 12, 1'b1, 4, 4);
`ifdef PINGPONG_RD_LAST_EN
        for (int k = 0; k < 16; k++)
            check($sformatf("alt_last%0d", k), 32'(acc_last[ab+k]), 32'((k % 4) == 3));
`endif

        // Threshold: only B eligible, then only A
        sb = strb_src.size(); ab = acc_data.size();
        a_cnt = 5'd3; b_cnt = 5'd4;
        wait_strobes(sb + 1, "thr_b");
        check("thr_busy", 32'(busy), 32'd1);
        b_cnt = '0; a_cnt = 5'd4;
        wait_strobes(sb + 5, "thr_a");
        a_cnt = 5'd3; b_cnt = 5'd3;
        step(15);
        check("thr_strobes", 32'(strb_src.size() - sb), 32'd8);
        check_words("thr_b", ab,     1'b1, 8, 4);
        check_words("thr_a", ab + 4, 1'b0, 12, 4);
        check("thr_idle_busy",  32'(busy),       32'd0);
        check("thr_idle_valid", 32'(dout_valid), 32'd0);

        // Backpressure mid-burst
        sb = strb_src.size(); ab = acc_data.size();
        a_cnt = 5'd4;
        wait_strobes(sb + 2, "bp");
        dout_ready = 1'b0; a_cnt = '0;
        step(10);
        check("bp_strobes", 32'(strb_src.size() - sb), 32'd2);
        check("bp_accepts", 32'(acc_data.size() - ab), 32'd0);
        check("bp_valid",   32'(dout_valid), 32'd1);
        check("bp_dout",    32'(dout),       32'hA010);
        check("bp_rd_en",   32'(a_rd_en),    32'd0);
        dout_ready = 1'b1;
        step(10);
        check("bp_total", 32'(acc_data.size() - ab), 32'd4);
        check_words("bp", ab, 1'b0, 16, 4);

        // Empty rises mid-burst: stall, then complete
        sb = strb_src.size(); ab = acc_data.size();
        a_cnt = 5'd4; b_cnt = '0;
        wait_strobes(sb + 2, "es");
        a_empty = 1'b1; a_cnt = '0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("es_rd_en%0d", i), 32'(a_rd_en), 32'd0);
            step(1);
        end
        check("es_hold", 32'(strb_src.size() - sb), 32'd2);
        a_empty = 1'b0;
        step(12);
        check("es_strobes", 32'(strb_src.size() - sb), 32'd4);
        check_words("es", ab, 1'b0, 20, 4);

        // Reset mid-burst discards everything; next burst restarts from A
        ab = acc_data.size();
        sb = strb_src.size();
        a_cnt = 5'd4; b_cnt = 5'd4;
        wait_strobes(sb + 2, "mr");
        rst_n = 1'b0;
        #1;
        check("mr_a_rd_en", 32'(a_rd_en),    32'd0);
        check("mr_b_rd_en", 32'(b_rd_en),    32'd0);
        check("mr_valid",   32'(dout_valid), 32'd0);
        check("mr_busy",    32'(busy),       32'd0);
        check("mr_dout",    32'(dout),       32'd0);
        step(2);
        rst_n = 1'b1;
        sb = strb_src.size();
        wait_strobes(sb + 1, "mr_next");
        a_cnt = '0; b_cnt = '0;
        step(10);
        check("mr_src",     32'(strb_src[sb]), 32'd0);
        check("mr_strobes", 32'(strb_src.size() - sb), 32'd4);
        check("mr_words",   32'(acc_data.size() - ab), 32'd4);
        check_words("mr", ab, 1'b0, 26, 4);

        check("no_spec_reads", 32'(viol),     32'd0);
        check("dout_stable",   32'(stab_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pingpong_rd_arb.md
# pingpong_rd_arb

Read-domain consumer for the ping-pong buffer pair: it drives the read side of two asynchronous FIFOs (buffer A, buffer B) and merges their contents into one valid/ready output stream. It transfers fixed-length bursts, alternating between buffers, and starts a burst only when the chosen FIFO already holds a full burst. It sits in the `rd_clk` domain, directly behind both FIFO read controllers.

## Interface

Parameters:
- `DATA_SIZE`, 16, data width
- `DEPTH_SIZE`, 10, FIFO address width; depth is 2^DEPTH_SIZE
- `BURST_LEN`, 256, words per burst; range 1..2^DEPTH_SIZE

Ports:
- `rd_clk` in 1, read-domain clock
- `rst_n` in 1, reset, asynchronous, active-low
- `a_empty` in 1, buffer A empty flag (registered)
- `a_rd_data_count` in DEPTH_SIZE+1, words readable in A
- `a_rd_data` in DATA_SIZE, A RAM output, valid one cycle after `a_rd_en`
- `a_rd_en` out 1, read strobe to A
- `b_empty`, `b_rd_data_count`, `b_rd_data`, `b_rd_en`, same as the A ports, for buffer B
- `dout` out DATA_SIZE, output word
- `dout_valid` out 1, `dout` holds a word
- `dout_ready` in 1, sink accepts the word
- `dout_src` out 1, source of the current word: 0 = A, 1 = B
- `busy` out 1, a burst is active or words are in flight or buffered
- `dout_last` out 1, present only with `PINGPONG_RD_LAST_EN`

## Operation

- **FSM states:** IDLE, BURST_A, BURST_B.
- **IDLE:**
  - A is eligible when `a_rd_data_count >= BURST_LEN`; B likewise.
  - The `prio` bit selects which buffer is checked first. It resets to A and toggles at the end of every burst.
  - If the preferred buffer is eligible, go to its BURST state. Otherwise, if the other buffer is eligible, go to the other. Otherwise stay in IDLE.
- **BURST_x:**
  - `x_rd_en` = `!x_empty && credit_ok`. The other buffer's `rd_en` stays 0.
  - `issue_cnt` increments on each strobe.
  - When the strobe issuing word BURST_LEN fires, return to IDLE on the next cycle and toggle `prio`.
- **No speculative reads:** `rd_en` is never asserted while the matching `empty` is 1.
- **Credit:** `credit_ok` = (`occ` + `inflight` − `pop`) < 2, where:
  - `occ` is the output buffer occupancy (0..2);
  - `inflight` = 1 if a strobe was issued in the previous cycle;
  - `pop` = `dout_valid && dout_ready`.
  - This sustains one word per cycle while the sink is ready.
- **Capture:** RAM data is written into a 2-entry in-order output buffer one cycle after the strobe. The `dout_src` tag is stored with each word.
- **Arithmetic:** `issue_cnt` width is $clog2(BURST_LEN+1). Counts are compared unsigned at width DEPTH_SIZE+1.
- **Boundaries:**
  - Both buffers eligible in IDLE: `prio` decides, giving strict alternation.
  - `empty` rises mid-burst because of a stale count: stall `rd_en` and hold the state until `empty` falls. The burst is never truncated.
  - `dout_ready` low: the buffer fills to 2, `rd_en` drops, and no data is lost.
  - Reset asserted mid-burst: state, counters, buffer, `prio` and in-flight data are all discarded. No outputs glitch high.
- **Reset values:** `a_rd_en`, `b_rd_en`, `dout_valid`, `dout_src`, `busy`, `dout_last` = 0; `dout` = 0; state = IDLE; `prio` = A.

## Timing

- `rd_en` in cycle N → RAM data in cycle N+1 → captured at the end of N+1 → `dout_valid` from N+2 at the earliest (2-cycle latency).
- IDLE → BURST: one decision cycle after eligibility is seen; the first strobe is in the first BURST cycle.
- BURST → IDLE → next BURST: minimum 2-cycle gap between the last strobe of one burst and the first strobe of the next.
- `rd_en` is registered-free (combinational from state, `empty` and credit). `dout`, `dout_valid` and `dout_src` come from flops.
- `dout_valid` stays high and `dout` stays stable until accepted.

## Configuration

- `PINGPONG_RD_LAST_EN` defined:
  - The `dout_last` port exists and is stored alongside each word.
  - It is 1 on the word that completed a burst (issue index BURST_LEN) and 0 otherwise.
- Not defined: the port and its storage are absent. Behaviour is otherwise identical.

## Structure

- Shared package `pingpong_rd_pkg`:
  - state enum (IDLE, BURST_A, BURST_B);
  - localparams `SRC_A` = 0 and `SRC_B` = 1;
  - output buffer depth = 2.
- Sub-module `rd_out_skid`: the 2-entry FIFO-ordered output buffer with data, src and optional last. It exposes `occ`, push and pop.
- The FSM, credit logic and counters stay in the top module.

## Test plan

Use DEPTH_SIZE=4 and BURST_LEN=4 unless stated otherwise.
- **Reset:** assert `rst_n`=0 with both counts at 8 → all outputs 0, no `rd_en`. Release → first burst from A: four `a_rd_en` pulses on consecutive cycles, `dout` = A0..A3 with `dout_src`=0, first `dout_valid` 2 cycles after the first strobe.
- **Alternation:** both counts held at 16, `dout_ready`=1 → burst order A, B, A, B. Each burst is exactly 4 words. With `PINGPONG_RD_LAST_EN`, `dout_last`=1 on words 4, 8, 12, 16 only.
- **Threshold:** `a_rd_data_count`=3, `b_rd_data_count`=4 → B is served. Raise A to 4 → A is served next. Both at 3 → block stays IDLE with `busy`=0.
- **Backpressure:** `dout_ready`=0 for 10 cycles mid-burst → at most 2 words buffered, `rd_en` low, `dout` stable. Release → remaining words delivered in order with no loss or duplication.
- **Empty stall:** force `a_empty`=1 for 3 cycles after word 2 → `a_rd_en` stays 0 throughout. After `a_empty` falls, words 3 and 4 are delivered and the burst completes.
- **Reset mid-burst:** assert reset after 2 strobes → outputs go to 0 immediately. After release, the next burst starts from A with `issue_cnt`=0.
